// File: rtl/reg_write_arbiter_if.sv
// Bus bundle for reg_write_arbiter: request/data side plus the shared register view.
// REG_ARB_PARITY_EN adds q_par to the bundle.
interface reg_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic                      clr;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         q;
   logic [IDX_W-1:0]          q_owner;
   logic                      q_valid;
   logic                      busy;
`ifdef REG_ARB_PARITY_EN
   logic                      q_par;

   modport master (
      output clr, req, wdata,
      input  ack, q, q_owner, q_valid, busy, q_par
   );

   modport slave (
      input  clr, req, wdata,
      output ack, q, q_owner, q_valid, busy, q_par
   );
`else
   modport master (
      output clr, req, wdata,
      input  ack, q, q_owner, q_valid, busy
   );

   modport slave (
      input  clr, req, wdata,
      output ack, q, q_owner, q_valid, busy
   );
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one holding register among NUM_REQ writers (IDLE/CAPTURE/ACK).
// Optional REG_ARB_PARITY_EN: registers even parity of q as q_par.
module reg_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input logic                clk,
   input logic                rst_n,
   reg_write_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      ACK     = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   gnt;
   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   idx;
   logic               found;
   logic [DATA_W-1:0]  sel_data;
   logic [NUM_REQ-1:0] ack_r;
   logic [DATA_W-1:0]  q_r;
   logic [IDX_W-1:0]   owner_r;
   logic               valid_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // clr wins over req: no grant in a clearing cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!bus.clr && (|bus.req)) state_nxt = CAPTURE;
         CAPTURE: state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pick  = ptr;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
         if (!found && bus.req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt == IDX_W'(i)) sel_data = bus.wdata[i*DATA_W +: DATA_W];
      end
   end

`ifdef REG_ARB_PARITY_EN
   logic q_par_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= IDX_W'(NUM_REQ - 1);
         gnt     <= '0;
         ack_r   <= '0;
         q_r     <= '0;
         owner_r <= '0;
         valid_r <= 1'b0;
`ifdef REG_ARB_PARITY_EN
         q_par_r <= 1'b0;
`endif
      end else begin
         ack_r <= '0;
         case (state)
            IDLE: begin
               if (bus.clr) begin
                  q_r     <= '0;
                  valid_r <= 1'b0;
`ifdef REG_ARB_PARITY_EN
                  q_par_r <= 1'b0;
`endif
               end else if (|bus.req) begin
                  gnt <= pick;
               end
            end
            CAPTURE: begin
               q_r     <= sel_data;
               owner_r <= gnt;
               valid_r <= 1'b1;
               ack_r   <= NUM_REQ'(1) << gnt;
`ifdef REG_ARB_PARITY_EN
               q_par_r <= ^sel_data;
`endif
            end
            ACK:     ptr <= gnt;
            default: ;
         endcase
      end
   end

   assign bus.ack     = ack_r;
   assign bus.q       = q_r;
   assign bus.q_owner = owner_r;
   assign bus.q_valid = valid_r;
   assign bus.busy    = (state != IDLE);
`ifdef REG_ARB_PARITY_EN
   assign bus.q_par   = q_par_r;
`endif

endmodule
